vtage_updater: RTL

- Commit-side update controller for one VTAGE bank. It drives the bank's feedback-probe and update ports.
- Accepts resolved-value records from the commit stage through a valid/ready handshake and buffers them in a FIFO.
- Processes records one at a time: probes the bank entry, then issues a single-cycle update or allocation pulse.
- One instance per bank. Single lane; the top level ties it to bank lane 0.

---
 rtl/vtage_updater.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vtage_updater.sv
// vtage_updater: commit-side update controller for one VTAGE bank.
// Commit records are buffered in a small FIFO. Each record is handled in two
// steps. First a PROBE cycle reads the bank's feedback port. Then an ACT cycle
// pulses the matching update strobes for one cycle.
// Optional feature: define VTAGE_UPD_STATS_EN to add three 16-bit saturating
// statistics counters (stat_update_o, stat_alloc_o, stat_alloc_fail_o).
//
// Handshake: a commit record transfers on a rising clk_i edge where both
// cm_valid_i and cm_ready_o are high. cm_ready_o does not depend on cm_valid_i.
// cm_ready_o is low while rst_i is high or while the FIFO is full.
module vtage_updater #(
  parameter int P_NUM_ENTRIES = 256,
  parameter int P_TAG_WIDTH   = 8,
  parameter int P_VALUE_WIDTH = 8,
  parameter int P_FIFO_DEPTH  = 4,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // commit record input
  input  logic                      cm_valid_i,
  output logic                      cm_ready_o,
  input  logic [LP_INDEX_WIDTH-1:0] cm_index_i,
  input  logic [P_TAG_WIDTH-1:0]    cm_tag_i,
  input  logic [P_VALUE_WIDTH-1:0]  cm_pred_value_i,
  input  logic [P_VALUE_WIDTH-1:0]  cm_actual_value_i,
  input  logic                      cm_alloc_i,
  // bank feedback probe
  output logic [LP_INDEX_WIDTH-1:0] fb_index_o,
  output logic [P_TAG_WIDTH-1:0]    fb_tag_o,
  input  logic                      fb_tag_match_i,
  input  logic                      fb_alloc_avail_i,
  // bank update port
  output logic [LP_INDEX_WIDTH-1:0] ud_index_o,
  output logic                      ud_incr_conf_o,
  output logic                      ud_rst_conf_o,
  output logic                      ud_incr_use_o,
  output logic                      ud_decr_use_o,
  output logic                      ud_rst_use_o,
  output logic                      ud_load_tag_o,
  output logic                      ud_load_value_o,
  output logic [P_TAG_WIDTH-1:0]    ud_tag_o,
  output logic [P_VALUE_WIDTH-1:0]  ud_value_o,
  // status
  output logic                      busy_o,
  output logic                      alloc_fail_o,
  output logic [1:0]                dbg_state_o
`ifdef VTAGE_UPD_STATS_EN
  ,
  output logic [15:0]               stat_update_o,
  output logic [15:0]               stat_alloc_o,
  output logic [15:0]               stat_alloc_fail_o
`endif
);

  localparam int LP_PTR_WIDTH = $clog2(P_FIFO_DEPTH);
  localparam int LP_CNT_WIDTH = LP_PTR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_ACT   = 2'd2;

  localparam logic [LP_CNT_WIDTH-1:0] LP_FULL_CNT = LP_CNT_WIDTH'(P_FIFO_DEPTH);
  localparam logic [LP_CNT_WIDTH-1:0] LP_CNT_ONE  = LP_CNT_WIDTH'(1);

  // FIFO storage, one array per record field
  logic [LP_INDEX_WIDTH-1:0] mem_index_q  [P_FIFO_DEPTH];
  logic [P_TAG_WIDTH-1:0]    mem_tag_q    [P_FIFO_DEPTH];
  logic [P_VALUE_WIDTH-1:0]  mem_pred_q   [P_FIFO_DEPTH];
  logic [P_VALUE_WIDTH-1:0]  mem_actual_q [P_FIFO_DEPTH];
  logic                      mem_alloc_q  [P_FIFO_DEPTH];

  logic [LP_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LP_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LP_CNT_WIDTH-1:0] count_q, count_d;

  logic [1:0] state_q, state_d;
  logic       match_q, match_d;
  logic       avail_q, avail_d;

  logic push;
  logic pop;
  logic full;

  logic [LP_INDEX_WIDTH-1:0] head_index;
  logic [P_TAG_WIDTH-1:0]    head_tag;
  logic [P_VALUE_WIDTH-1:0]  head_pred;
  logic [P_VALUE_WIDTH-1:0]  head_actual;
  logic                      head_alloc;

  // action classes, valid only in ACT
  logic act_hit_ok;
  logic act_hit_bad;
  logic act_alloc_ok;
  logic act_alloc_fail;

  assign full        = (count_q == LP_FULL_CNT);
  assign cm_ready_o  = !rst_i && !full;
  assign push        = cm_valid_i && cm_ready_o;
  assign pop         = (state_q == S_ACT);
  assign busy_o      = (count_q != '0) || (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  assign head_index  = mem_index_q[rd_ptr_q];
  assign head_tag    = mem_tag_q[rd_ptr_q];
  assign head_pred   = mem_pred_q[rd_ptr_q];
  assign head_actual = mem_actual_q[rd_ptr_q];
  assign head_alloc  = mem_alloc_q[rd_ptr_q];

  assign act_hit_ok     = pop &&  match_q && (head_actual == head_pred);
  assign act_hit_bad    = pop &&  match_q && (head_actual != head_pred);
  assign act_alloc_ok   = pop && !match_q && head_alloc &&  avail_q;
  assign act_alloc_fail = pop && !match_q && head_alloc && !avail_q;

  // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + LP_CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - LP_CNT_ONE;
    end
  end

  // FSM next state; leaving IDLE or ACT looks at the post-update occupancy
  // so a record pushed this cycle is probed in the very next cycle
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    avail_d = avail_q;
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) begin
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        match_d = fb_tag_match_i;
        avail_d = fb_alloc_avail_i;
        state_d = S_ACT;
      end
      S_ACT: begin
        state_d = (count_d != '0) ? S_PROBE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control state registers; reset discards buffered records and pending work
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      match_q  <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      match_q  <= match_d;
      avail_q  <= avail_d;
    end
  end

  // FIFO payload write; contents are qualified by count_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_index_q[wr_ptr_q]  <= cm_index_i;
      mem_tag_q[wr_ptr_q]    <= cm_tag_i;
      mem_pred_q[wr_ptr_q]   <= cm_pred_value_i;
      mem_actual_q[wr_ptr_q] <= cm_actual_value_i;
      mem_alloc_q[wr_ptr_q]  <= cm_alloc_i;
    end
  end

  // bank-facing outputs: probe fields only in PROBE, update fields only in ACT
  always_comb begin
    fb_index_o      = '0;
    fb_tag_o        = '0;
    ud_index_o      = '0;
    ud_tag_o        = '0;
    ud_value_o      = '0;
    ud_incr_conf_o  = 1'b0;
    ud_rst_conf_o   = 1'b0;
    ud_incr_use_o   = 1'b0;
    ud_decr_use_o   = 1'b0;
    ud_rst_use_o    = 1'b0;
    ud_load_tag_o   = 1'b0;
    ud_load_value_o = 1'b0;
    alloc_fail_o    = 1'b0;
    if (state_q == S_PROBE) begin
      fb_index_o = head_index;
      fb_tag_o   = head_tag;
    end
    if (pop) begin
      ud_index_o = head_index;
    end
    if (act_hit_ok) begin
      ud_incr_conf_o = 1'b1;
      ud_incr_use_o  = 1'b1;
    end
    if (act_hit_bad) begin
      ud_rst_conf_o   = 1'b1;
      ud_decr_use_o   = 1'b1;
      ud_load_value_o = 1'b1;
      ud_value_o      = head_actual;
    end
    if (act_alloc_ok) begin
      ud_load_tag_o   = 1'b1;
      ud_tag_o        = head_tag;
      ud_load_value_o = 1'b1;
      ud_value_o      = head_actual;
      ud_rst_conf_o   = 1'b1;
      ud_rst_use_o    = 1'b1;
    end
    if (act_alloc_fail) begin
      // entry is still useful: age it so a later allocation can succeed
      ud_decr_use_o = 1'b1;
      alloc_fail_o  = 1'b1;
    end
  end

`ifdef VTAGE_UPD_STATS_EN
  logic [15:0] stat_update_q, stat_alloc_q, stat_alloc_fail_q;

  // saturating event counters, one per action outcome
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_update_q     <= '0;
      stat_alloc_q      <= '0;
      stat_alloc_fail_q <= '0;
    end else begin
      if ((act_hit_ok || act_hit_bad) && (stat_update_q != 16'hFFFF)) begin
        stat_update_q <= stat_update_q + 16'd1;
      end
      if (act_alloc_ok && (stat_alloc_q != 16'hFFFF)) begin
        stat_alloc_q <= stat_alloc_q + 16'd1;
      end
      if (act_alloc_fail && (stat_alloc_fail_q != 16'hFFFF)) begin
        stat_alloc_fail_q <= stat_alloc_fail_q + 16'd1;
      end
    end
  end

  assign stat_update_o     = stat_update_q;
  assign stat_alloc_o      = stat_alloc_q;
  assign stat_alloc_fail_o = stat_alloc_fail_q;
`endif

endmodule
